// File: rtl/video_in_buf_ctrl.sv
// FIFO controller over an external dual-port RAM with a 2-entry prefetch output buffer.
// Optional synchronous flush port enabled by defining VIDEO_IN_BUF_FLUSH_EN.
module video_in_buf_ctrl #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef VIDEO_IN_BUF_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic [DATA_SIZE-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_SIZE-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_SIZE+1:0]   level,
  output logic [DATA_SIZE-1:0]   ram_data_in_A,
  output logic [ADDR_SIZE-1:0]   ram_addr_A,
  output logic                   ram_w_e_A,
  output logic [ADDR_SIZE-1:0]   ram_addr_B,
  input  logic [DATA_SIZE-1:0]   ram_data_out_B
);

  localparam int CNT_W = ADDR_SIZE + 1;
  localparam int LVL_W = ADDR_SIZE + 2;
  localparam logic [CNT_W-1:0]     DEPTH   = CNT_W'(2 ** ADDR_SIZE);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE-1:0] last_addr_b;
  logic [CNT_W-1:0]     ram_count;
  logic                 fetch;
  logic [1:0]           obuf_count;
  logic                 obuf_head;
  logic [DATA_SIZE-1:0] obuf [2];

  logic       clr;
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ;

`ifdef VIDEO_IN_BUF_FLUSH_EN
  assign clr = reset | flush;
`else
  assign clr = reset;
`endif

  assign in_ready      = ram_count < DEPTH;
  assign push          = in_valid & in_ready & ~clr;
  assign ram_w_e_A     = push;
  assign ram_addr_A    = wr_ptr;
  assign ram_data_in_A = in_data;

  assign out_valid = obuf_count != 2'd0;
  assign out_data  = obuf[obuf_head];
  assign pop       = out_valid & out_ready;

  // Prefetch only while the words already buffered or in flight, less this
  // cycle's pop, leave a free obuf slot for the returning read.
  assign occ   = {1'b0, obuf_count} + {2'b00, fetch};
  assign issue = (ram_count != '0) && (occ < (3'd2 + {2'b00, pop}));

  // RAM port B registers its address, so the read address is presented
  // combinationally in the issue cycle and held afterwards.
  assign ram_addr_B = issue ? rd_ptr : last_addr_b;

  assign level = LVL_W'(ram_count) + LVL_W'(fetch) + LVL_W'(obuf_count);

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_addr_b <= '0;
      ram_count   <= '0;
      fetch       <= 1'b0;
      obuf_count  <= 2'd0;
      obuf_head   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        last_addr_b <= rd_ptr;
      end
      case ({push, issue})
        2'b10:   ram_count <= ram_count + CNT_ONE;
        2'b01:   ram_count <= ram_count - CNT_ONE;
        default: ram_count <= ram_count;
      endcase
      fetch <= issue;
      if (pop)
        obuf_head <= ~obuf_head;
      obuf_count <= obuf_count + {1'b0, fetch} - {1'b0, pop};
    end
  end

  // Returning read lands at the tail; obuf holds at most one word whenever a
  // fetch returns, so the tail is the head slot or the one after it.
  always_ff @(posedge clk) begin
    if (fetch && !clr)
      obuf[obuf_head ^ obuf_count[0]] <= ram_data_out_B;
  end

endmodule

// File: tb/tb_video_in_buf_ctrl.sv
// Bench for video_in_buf_ctrl: RAM model, queue-based reference model checked every cycle,
// and directed sequences with literal expectations. Flush section needs VIDEO_IN_BUF_FLUSH_EN.
module tb_video_in_buf_ctrl;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset;
`ifdef VIDEO_IN_BUF_FLUSH_EN
  logic          flush;
`endif
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW+1:0] level;
  logic [DW-1:0] ram_data_in_A;
  logic [AW-1:0] ram_addr_A;
  logic          ram_w_e_A;
  logic [AW-1:0] ram_addr_B;
  logic [DW-1:0] rd_q;

  always #5 clk = ~clk;

  video_in_buf_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef VIDEO_IN_BUF_FLUSH_EN
    .flush          (flush),
`endif
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .level          (level),
    .ram_data_in_A  (ram_data_in_A),
    .ram_addr_A     (ram_addr_A),
    .ram_w_e_A      (ram_w_e_A),
    .ram_addr_B     (ram_addr_B),
    .ram_data_out_B (rd_q)
  );

  // external RAM: write port A, registered read port B
  logic [DW-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_w_e_A) mem[ram_addr_A] <= ram_data_in_A;
    rd_q <= mem[ram_addr_B];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  int m_ram = 0, m_fl = 0, m_ob = 0, m_wr = 0, n_push = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  int            pop_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference: words held = pushes - pops; data order from a queue; the RAM
  // side accepts while fewer than D words sit in RAM.
  always @(negedge clk) begin
    int e_push, e_pop, e_issue, clr_now;
    if (chk_en) begin
      clr_now = reset ? 1 : 0;
`ifdef VIDEO_IN_BUF_FLUSH_EN
      if (flush) clr_now = 1;
`endif
      check("in_ready", in_ready, m_ram < D);
      check("out_valid", out_valid, m_ob > 0);
      if (m_ob > 0 && q.size() > 0) check("out_data", out_data, q[0]);
      check("level", level, m_ram + m_fl + m_ob);
      check("level_max", level <= 10, 1);
      e_push = (in_valid && m_ram < D && clr_now == 0) ? 1 : 0;
      check("ram_w_e_A", ram_w_e_A, e_push);
      if (e_push == 1) begin
        check("ram_addr_A", ram_addr_A, m_wr);
        check("ram_data_in_A", ram_data_in_A, in_data);
      end
      e_pop   = (m_ob > 0 && out_ready) ? 1 : 0;
      e_issue = (m_ram > 0 && (m_ob + m_fl - e_pop) < 2) ? 1 : 0;
      if (clr_now == 1) begin
        m_ram = 0; m_fl = 0; m_ob = 0; m_wr = 0;
        q.delete();
      end else begin
        if (e_pop == 1) begin
          popped.push_back(q.pop_front());
          pop_cyc.push_back(cyc);
        end
        if (e_push == 1) begin
          q.push_back(in_data);
          m_wr = (m_wr + 1) % D;
          n_push++;
        end
        m_ram = m_ram + e_push - e_issue;
        m_ob  = m_ob + m_fl - e_pop;
        m_fl  = e_issue;
      end
    end
  end

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic rst);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int found;
`ifdef VIDEO_IN_BUF_FLUSH_EN
    flush = 1'b0;
`endif
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; reset = 1'b1;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk_en = 1'b1;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);

    // single word latency
    drive(1, 32'h11, 1, 0);
    check("lat_level_t", level, 1);
    drive(0, 0, 1, 0);
    check("lat_ov_t1", out_valid, 0);
    drive(0, 0, 1, 0);
    check("lat_ov_t2", out_valid, 1);
    check("lat_data_t2", out_data, 32'h11);
    check("lat_level_t2", level, 1);
    drive(0, 0, 1, 0);
    check("lat_level_pop", level, 0);

    // fill with consumer stalled
    for (int i = 0; i < 12; i++) drive(1, DW'(i), 0, 0);
    check("full_in_ready", in_ready, 0);
    check("full_level", level, 10);
    popped.delete();
    repeat (16) drive(0, 0, 1, 0);
    check("full_drain_cnt", popped.size(), 10);
    if (popped.size() == 10) begin
      check("full_first", popped[0], 0);
      check("full_last", popped[9], 9);
    end

    // streaming across pointer wrap
    popped.delete(); pop_cyc.delete();
    for (int i = 0; i < 20; i++) drive(1, DW'(i), 1, 0);
    repeat (6) drive(0, 0, 1, 0);
    check("stream_cnt", popped.size(), 20);
    if (popped.size() == 20) begin
      check("stream_first", popped[0], 0);
      check("stream_last", popped[19], 19);
      check("stream_rate", pop_cyc[19] - pop_cyc[0], 19);
    end

    // reset with 5 held and a fetch in flight
    for (int i = 1; i <= 5; i++) drive(1, DW'(i), 0, 0);
    drive(1, 32'h66, 1, 0);
    check("pre_rst_level", level, 5);
    drive(0, 0, 0, 1);
    check("mid_rst_level", level, 0);
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_ir", in_ready, 1);
    popped.delete();
    drive(1, 32'hAA, 1, 0);
    repeat (4) drive(0, 0, 1, 0);
    check("post_rst_cnt", popped.size(), 1);
    if (popped.size() > 0) check("post_rst_first", popped[0], 32'hAA);

`ifdef VIDEO_IN_BUF_FLUSH_EN
    for (int i = 1; i <= 4; i++) drive(1, DW'(32'h40 + i), 0, 0);
    flush = 1'b1;
    drive(1, 32'h55, 0, 0);
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_ov", out_valid, 0);
    popped.delete();
    drive(1, 32'h77, 1, 0);
    repeat (4) drive(0, 0, 1, 0);
    found = 0;
    foreach (popped[k]) if (popped[k] == 32'h55) found = 1;
    check("flush_no_55", found, 0);
    if (popped.size() > 0) check("flush_first", popped[0], 32'h77);
`endif

    // random handshakes
    n0 = n_push;
    for (int k = 0; k < 6000 && (n_push - n0) < 1000; k++)
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 0);
    check("rand_done", (n_push - n0) >= 1000, 1);
    repeat (20) drive(0, 0, 1, 0);
    check("rand_drain_level", level, 0);
    check("rand_drain_ov", out_valid, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
